// File: rtl/div_sequencer.sv
// Sequencer for the shared multi-cycle signed divider. It accepts one divide at a time,
// issues the start pulse, collects the quotient and holds it until writeback takes it.
module div_sequencer #(
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic [31:0]      div_operandA,
   output logic [31:0]      div_operandB,
   output logic             ctrl_DIV,
   input  logic             div_ready,
   input  logic [31:0]      div_result,
   input  logic             div_exception,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [31:0]      wb_data,
   output logic [TAG_W-1:0] wb_tag,
   output logic             wb_exception,
   output logic             busy_tag_valid,
   output logic [TAG_W-1:0] busy_tag,
   output logic             timeout_err,
   output logic [2:0]       state_dbg
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wd_cnt;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [TAG_W-1:0] tag_q;
   logic [31:0]      wb_data_q;
   logic [TAG_W-1:0] wb_tag_q;
   logic             wb_exc_q;
   logic             timeout_q;

   // Handshakes: a request transfers on a cycle with req_valid & req_ready; a result
   // transfers on a cycle with wb_valid & wb_ready. Neither side may retract data
   // early, and the result registers hold stable while wb_valid is high.
   assign req_ready      = (state == IDLE) & ~flush;
   assign ctrl_DIV       = (state == START) & ~flush;
   assign wb_valid       = (state == DONE);
   assign busy_tag_valid = (state == START) | (state == WAIT) | (state == DONE);
   assign busy_tag       = tag_q;
   assign div_operandA   = op_a;
   assign div_operandB   = op_b;
   assign wb_data        = wb_data_q;
   assign wb_tag         = wb_tag_q;
   assign wb_exception   = wb_exc_q;
   assign timeout_err    = timeout_q;
   assign state_dbg      = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wd_cnt    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         tag_q     <= '0;
         wb_data_q <= '0;
         wb_tag_q  <= '0;
         wb_exc_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         // The watchdog spans WAIT and DRAIN together so a flushed divide cannot reset it.
         if ((state == WAIT || state == DRAIN) && wd_cnt != CNT_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (req_valid && !flush) begin
                  op_a  <= req_a;
                  op_b  <= req_b;
                  tag_q <= req_tag;
                  state <= START;
               end
            end

            START: begin
               wd_cnt <= '0;
               state  <= flush ? IDLE : WAIT;
            end

            WAIT: begin
               if (flush) begin
                  // A result arriving with the flush is simply dropped; otherwise the
                  // divider is still busy and has to finish before it can be reused.
                  state <= div_ready ? IDLE : DRAIN;
               end else if (div_ready) begin
                  wb_data_q <= div_result;
                  wb_exc_q  <= div_exception;
                  wb_tag_q  <= tag_q;
                  state     <= DONE;
               end else if (wd_cnt >= CNT_LAST) begin
                  timeout_q <= 1'b1;
                  wb_data_q <= '0;
                  wb_exc_q  <= 1'b1;
                  wb_tag_q  <= tag_q;
                  state     <= DONE;
               end
            end

            DONE: begin
               if (flush || wb_ready) begin
                  state <= IDLE;
               end
            end

            DRAIN: begin
               if (div_ready) begin
                  state <= IDLE;
               end else if (wd_cnt >= CNT_LAST) begin
                  timeout_q <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
